// File: rtl/regfile_mp.sv
// Multi-read-port register file with an optional hardwired zero register and a sequenced clear on reset.
// Define REGFILE_BYPASS_EN to forward same-cycle write data to matching read ports.
module regfile_mp #(
    parameter int WIDTH    = 32,
    parameter int DEPTH    = 32,
    parameter int NREAD    = 2,
    parameter int ZERO_REG = 1,
    localparam int ADDR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    we,
    input  logic [ADDR_W-1:0]       wa,
    input  logic [WIDTH-1:0]        wd,
    input  logic [NREAD*ADDR_W-1:0] ra,
    output logic [NREAD*WIDTH-1:0]  rd,
    output logic                    busy
);

    if (NREAD < 1 || DEPTH < 2) begin : gBadParams
        $error("regfile_mp: NREAD must be >= 1 and DEPTH must be >= 2");
    end

    localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_PTR  = ADDR_W'(DEPTH - 1);

    typedef enum logic {
        CLEAR,
        RUN
    } state_t;

    state_t            state_q;
    logic              busy_q;
    logic [ADDR_W-1:0] clrPtr_q;
    logic [ADDR_W-1:0] clrPtr_d;
    logic [WIDTH-1:0]  rf_q [DEPTH];
    logic              wrValid;

    // An address is usable when it maps to a real, non-hardwired register.
    function automatic logic addrValid(input logic [ADDR_W-1:0] a);
        return ({1'b0, a} < DEPTH_EXT) && !((ZERO_REG != 0) && (a == '0));
    endfunction

    assign clrPtr_d = clrPtr_q + ADDR_W'(1);
    assign wrValid  = we && !busy_q && addrValid(wa);
    assign busy     = busy_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= CLEAR;
            clrPtr_q <= '0;
            busy_q   <= 1'b1;
        end else begin
            case (state_q)
                CLEAR: begin
                    rf_q[clrPtr_q] <= '0;
                    clrPtr_q       <= clrPtr_d;
                    if (clrPtr_q == LAST_PTR) begin
                        state_q <= RUN;
                        busy_q  <= 1'b0;
                    end
                end
                RUN: begin
                    if (wrValid) begin
                        rf_q[wa] <= wd;
                    end
                end
                default: state_q <= CLEAR;
            endcase
        end
    end

    for (genvar g = 0; g < NREAD; g++) begin : gRead
        logic [ADDR_W-1:0] rAddr;
        logic [WIDTH-1:0]  rData;

        assign rAddr = ra[g*ADDR_W +: ADDR_W];

        // Reads return zero while clearing or for unmapped / hardwired addresses.
        always_comb begin
            rData = '0;
            if (!busy_q && addrValid(rAddr)) begin
                rData = rf_q[rAddr];
            end
`ifdef REGFILE_BYPASS_EN
            if (wrValid && (rAddr == wa)) begin
                rData = wd;
            end
`endif
        end

        assign rd[g*WIDTH +: WIDTH] = rData;
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp: default, ZERO_REG=0 and 16x20x4 configurations.
// Expectations follow REGFILE_BYPASS_EN when the bench is built with it.
module tb_regfile_mp;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [9:0]  ra;
    logic [63:0] rd;
    logic        busy;
    logic [63:0] rdZ;
    logic        busyZ;

    logic        gRst;
    logic        gWe;
    logic [4:0]  gWa;
    logic [15:0] gWd;
    logic [19:0] gRa;
    logic [63:0] gRd;
    logic        gBusy;

    int nChecks = 0;
    int nFail   = 0;

    // Reference model: register contents plus the remaining clear length
    logic [31:0] mem [32];
    bit          busyM = 1'b0;
    int          clearLeft = 0;

    typedef struct {
        bit          we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic [4:0]  ra0;
        logic [4:0]  ra1;
        logic [31:0] exp0;
        logic [31:0] exp1;
        logic [31:0] expZ0;
        logic [31:0] expZ1;
    } vec_t;

    vec_t vecs [9];

    regfile_mp dut (
        .clk (clk), .rst (rst), .we (we), .wa (wa), .wd (wd),
        .ra  (ra),  .rd  (rd),  .busy (busy)
    );

    regfile_mp #(.ZERO_REG(0)) dutZ (
        .clk (clk), .rst (rst), .we (we), .wa (wa), .wd (wd),
        .ra  (ra),  .rd  (rdZ), .busy (busyZ)
    );

    regfile_mp #(.WIDTH(16), .DEPTH(20), .NREAD(4)) dutG (
        .clk (clk), .rst (gRst), .we (gWe), .wa (gWa), .wd (gWd),
        .ra  (gRa), .rd  (gRd),  .busy (gBusy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFail++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] modelRead(input logic [4:0] a, input bit zeroReg);
        logic [31:0] v;
        if (busyM) return 32'h0;
        v = (zeroReg && a == 5'd0) ? 32'h0 : mem[a];
        if (BYP && we && a == wa && !(zeroReg && wa == 5'd0)) v = wd;
        return v;
    endfunction

    task automatic applyStimulus(input bit r, input bit w, input logic [4:0] a, input logic [31:0] d,
                                 input logic [4:0] a0, input logic [4:0] a1);
        @(negedge clk);
        rst = r;
        we  = w;
        wa  = a;
        wd  = d;
        ra  = {a1, a0};
        #1;
    endtask

    task automatic stepClock();
        @(posedge clk);
        if (rst) begin
            busyM     = 1'b1;
            clearLeft = 32;
        end else if (busyM) begin
            clearLeft--;
            if (clearLeft == 0) begin
                foreach (mem[i]) mem[i] = 32'h0;
                busyM = 1'b0;
            end
        end else if (we) begin
            mem[wa] = wd;
        end
    endtask

    task automatic checkAllMain(input string tag);
        checkOutput({tag, " busy"},  32'(busy),  32'(busyM));
        checkOutput({tag, " busyZ"}, 32'(busyZ), 32'(busyM));
        checkOutput({tag, " rd0"},   rd[31:0],   modelRead(ra[4:0], 1'b1));
        checkOutput({tag, " rd1"},   rd[63:32],  modelRead(ra[9:5], 1'b1));
        checkOutput({tag, " rdZ0"},  rdZ[31:0],  modelRead(ra[4:0], 1'b0));
        checkOutput({tag, " rdZ1"},  rdZ[63:32], modelRead(ra[9:5], 1'b0));
    endtask

    // Counts edges with busy high, optionally attempting writes during the first few.
    task automatic countBusy(input logic [4:0] a, input logic [31:0] d, input int writeCycles, output int n);
        n = 0;
        for (int k = 0; k < 100; k++) begin
            applyStimulus(1'b0, (k < writeCycles), a, d, a, a);
            if (busy !== 1'b1) break;
            checkOutput("rd0 while busy", rd[31:0], 32'h0);
            checkOutput("busyZ while busy", 32'(busyZ), 32'h1);
            stepClock();
            n++;
        end
        stepClock();
    endtask

    task automatic applyGen(input bit r, input bit w, input logic [4:0] a, input logic [15:0] d,
                            input logic [19:0] rAddrs);
        @(negedge clk);
        gRst = r;
        gWe  = w;
        gWa  = a;
        gWd  = d;
        gRa  = rAddrs;
        #1;
    endtask

    initial begin
        int n;
        bit r, w;
        logic [4:0] a, a0, a1;
        logic [31:0] d;

        rst = 1'b0; we = 1'b0; wa = '0; wd = '0; ra = '0;
        gRst = 1'b0; gWe = 1'b0; gWa = '0; gWd = '0; gRa = '0;

        vecs[0] = '{1'b1, 5'd5, 32'hDEADBEEF, 5'd5, 5'd6, BYP ? 32'hDEADBEEF : 32'h0, 32'h0,
                    BYP ? 32'hDEADBEEF : 32'h0, 32'h0};
        vecs[1] = '{1'b0, 5'd0, 32'h0, 5'd5, 5'd5, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF};
        vecs[2] = '{1'b0, 5'd0, 32'h0, 5'd6, 5'd5, 32'h0, 32'hDEADBEEF, 32'h0, 32'hDEADBEEF};
        vecs[3] = '{1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd5, 32'h0, 32'hDEADBEEF,
                    BYP ? 32'hFFFFFFFF : 32'h0, 32'hDEADBEEF};
        vecs[4] = '{1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 32'h0, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFFF};
        vecs[5] = '{1'b1, 5'd7, 32'h12345678, 5'd7, 5'd0, BYP ? 32'h12345678 : 32'h0, 32'h0,
                    BYP ? 32'h12345678 : 32'h0, 32'hFFFFFFFF};
        vecs[6] = '{1'b0, 5'd0, 32'h0, 5'd7, 5'd3, 32'h12345678, 32'h0, 32'h12345678, 32'h0};
        vecs[7] = '{1'b1, 5'd3, 32'hAAAA5555, 5'd3, 5'd5, BYP ? 32'hAAAA5555 : 32'h0, 32'hDEADBEEF,
                    BYP ? 32'hAAAA5555 : 32'h0, 32'hDEADBEEF};
        vecs[8] = '{1'b0, 5'd0, 32'h0, 5'd3, 5'd7, 32'hAAAA5555, 32'h12345678, 32'hAAAA5555, 32'h12345678};

        $display("[TB] initial reset and clear");
        applyStimulus(1'b1, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
        stepClock();
        countBusy(5'd0, 32'h0, 0, n);
        checkOutput("first clear length", 32'(n), 32'd32);

        $display("[TB] directed vectors");
        for (int i = 0; i < 9; i++) begin
            applyStimulus(1'b0, vecs[i].we, vecs[i].wa, vecs[i].wd, vecs[i].ra0, vecs[i].ra1);
            checkOutput($sformatf("vec%0d busy", i), 32'(busy), 32'h0);
            checkOutput($sformatf("vec%0d rd0", i), rd[31:0], vecs[i].exp0);
            checkOutput($sformatf("vec%0d rd1", i), rd[63:32], vecs[i].exp1);
            checkOutput($sformatf("vec%0d rdZ0", i), rdZ[31:0], vecs[i].expZ0);
            checkOutput($sformatf("vec%0d rdZ1", i), rdZ[63:32], vecs[i].expZ1);
            stepClock();
        end

        $display("[TB] reset pulse clears preloaded contents");
        applyStimulus(1'b1, 1'b0, 5'd0, 32'h0, 5'd3, 5'd3);
        stepClock();
        countBusy(5'd0, 32'h0, 0, n);
        checkOutput("reclear length", 32'(n), 32'd32);
        for (int i = 0; i < 32; i += 2) begin
            applyStimulus(1'b0, 1'b0, 5'd0, 32'h0, 5'(i), 5'(i + 1));
            checkOutput($sformatf("cleared r%0d", i), rdZ[31:0], 32'h0);
            checkOutput($sformatf("cleared r%0d", i + 1), rd[63:32], 32'h0);
            stepClock();
        end

        $display("[TB] reset asserted mid-clear with dropped write");
        applyStimulus(1'b1, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
        stepClock();
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
            stepClock();
        end
        applyStimulus(1'b1, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
        stepClock();
        countBusy(5'd4, 32'h1, 5, n);
        checkOutput("restarted clear length", 32'(n), 32'd32);
        applyStimulus(1'b0, 1'b0, 5'd0, 32'h0, 5'd4, 5'd4);
        checkOutput("r4 after dropped write", rd[31:0], 32'h0);
        checkOutput("r4 after dropped write Z", rdZ[63:32], 32'h0);
        stepClock();

        $display("[TB] randomized traffic against model");
        for (int i = 0; i < 800; i++) begin
            r  = ($urandom_range(0, 79) == 0);
            w  = $urandom_range(0, 1) != 0;
            a  = 5'($urandom_range(0, 31));
            d  = $urandom;
            a0 = ($urandom_range(0, 3) == 0) ? a : 5'($urandom_range(0, 31));
            a1 = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
            applyStimulus(r, w, a, d, a0, a1);
            checkAllMain($sformatf("rand%0d", i));
            stepClock();
        end
        applyStimulus(1'b0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);

        $display("[TB] generalised 16x20x4 configuration");
        applyGen(1'b1, 1'b0, 5'd0, 16'h0, 20'h0);
        @(posedge clk);
        n = 0;
        for (int k = 0; k < 100; k++) begin
            applyGen(1'b0, 1'b0, 5'd0, 16'h0, 20'h0);
            if (gBusy !== 1'b1) break;
            @(posedge clk);
            n++;
        end
        @(posedge clk);
        checkOutput("gen clear length", 32'(n), 32'd20);
        applyGen(1'b0, 1'b1, 5'd1, 16'h0001, 20'h0);
        @(posedge clk);
        applyGen(1'b0, 1'b1, 5'd2, 16'h0002, 20'h0);
        @(posedge clk);
        applyGen(1'b0, 1'b1, 5'd19, 16'hBEEF, 20'h0);
        @(posedge clk);
        applyGen(1'b0, 1'b1, 5'd25, 16'h5A5A, {5'd25, 5'd25, 5'd25, 5'd25});
        checkOutput("gen write25 no forward", 32'(gRd[63:48]), 32'h0);
        @(posedge clk);
        applyGen(1'b0, 1'b0, 5'd0, 16'h0, {5'd25, 5'd19, 5'd2, 5'd1});
        checkOutput("gen busy", 32'(gBusy), 32'h0);
        checkOutput("gen port0 r1", 32'(gRd[15:0]), 32'h0001);
        checkOutput("gen port1 r2", 32'(gRd[31:16]), 32'h0002);
        checkOutput("gen port2 r19", 32'(gRd[47:32]), 32'hBEEF);
        checkOutput("gen port3 r25", 32'(gRd[63:48]), 32'h0000);
        @(posedge clk);
        applyGen(1'b0, 1'b0, 5'd0, 16'h0, {5'd0, 5'd19, 5'd19, 5'd9});
        checkOutput("gen port0 r9", 32'(gRd[15:0]), 32'h0);
        checkOutput("gen port1 r19", 32'(gRd[31:16]), 32'hBEEF);
        checkOutput("gen port2 r19", 32'(gRd[47:32]), 32'hBEEF);
        checkOutput("gen port3 r0", 32'(gRd[63:48]), 32'h0);
        @(posedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised multi-read-port register file for the MIPS datapath. Generalised in width, depth and read-port count.
- Adds a hardwired zero register and a synchronous reset that clears the whole array through a sequencer, with a busy flag while clearing.
- Optional write-to-read bypass for a later pipelined datapath.
- Sits between the instruction decode fields (rs/rt/rd) and the ALU operand muxes.

Parameters:
- WIDTH, 32, data word width in bits.
- DEPTH, 32, number of registers (any value ≥ 2; need not be a power of two).
- NREAD, 2, number of independent read ports.
- ZERO_REG, 1, when 1 register 0 always reads 0 and ignores writes; when 0 it is an ordinary register.
- Derived localparam ADDR_W = clog2(DEPTH), minimum 1.

Ports:
- clk  in  1  clock; all state changes on posedge.
- rst  in  1  synchronous active-high reset.
- we  in  1  write enable.
- wa  in  ADDR_W  write address.
- wd  in  WIDTH  write data.
- ra  in  NREAD*ADDR_W  packed read addresses; port i uses ra[i*ADDR_W +: ADDR_W].
- rd  out  NREAD*WIDTH  packed read data; port i uses rd[i*WIDTH +: WIDTH]; combinational from ra.
- busy  out  1  high while the clear sequence runs.

Behaviour:
- Synchronous, active-high reset. Posedge with rst=1: state<=CLEAR, clr_ptr<=0. Array contents are not touched on that edge. busy=1 from that edge onward.
- States are CLEAR and RUN.
- CLEAR, each posedge with rst=0:
  - RF[clr_ptr]<=0; clr_ptr<=clr_ptr+1.
  - When clr_ptr==DEPTH-1 the edge also sets state<=RUN.
  - busy therefore stays high for exactly DEPTH posedges after rst deasserts, and is low after the DEPTH-th edge.
- rst held high: remain in CLEAR with clr_ptr=0; no array writes.
- rst asserted mid-clear: clr_ptr restarts at 0; a full DEPTH-edge clear follows release.
- busy is a registered output, not decoded from clr_ptr combinationally. Its value before the first reset is undefined; a reset is mandatory.
- Reads while busy=1: all rd ports forced to 0, regardless of array contents.
- Writes while busy=1: we ignored entirely (dropped, not queued).
- RUN, posedge with we=1: RF[wa]<=wd, except:
  - ZERO_REG=1 and wa==0 → ignored.
  - wa ≥ DEPTH → ignored.
- Write latency: data is visible on rd combinationally in the cycle after the write edge.
- Read, RUN state: rd_i = RF[ra_i], except:
  - ZERO_REG=1 and ra_i==0 → 0.
  - ra_i ≥ DEPTH → 0.
- Read ports are fully independent. Several ports addressing the same register return identical data in the same cycle.
- Same-cycle read of the address being written: returns the old contents (pre-edge) unless the bypass macro is defined.
- No X propagation after a completed clear: every readable location is defined.
- Illegal parameters (NREAD<1, DEPTH<2) are a compile-time error via a generate-time $error.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined: a combinational forward applies when all of the following hold: busy=0, we=1, wa<DEPTH, (ZERO_REG==0 or wa≠0), and ra_i==wa. Then rd_i = wd in the same cycle; this is applied per port independently.
- Not defined: no forward path; same-cycle read returns the pre-write value.
- Array update timing is identical in both cases.

Test Plan:
- Reset clear, defaults: preload r3=0xAAAA5555, pulse rst for 1 cycle → busy=1 for exactly 32 posedges, then busy=0; r3 and all r1..r31 read 0x00000000.
- Basic write/read: write r5=0xDEADBEEF → next cycle ra0=5 and ra1=5 both return 0xDEADBEEF; ra0=6 returns 0.
- Zero register: write r0=0xFFFFFFFF with ZERO_REG=1 → r0 reads 0. Same with ZERO_REG=0 → r0 reads 0xFFFFFFFF.
- Bypass: r7 holds 0, drive we=1, wa=7, wd=0x12345678, ra0=7 in the same cycle:
  - Without REGFILE_BYPASS_EN → rd0=0 that cycle, 0x12345678 the next.
  - With REGFILE_BYPASS_EN → rd0=0x12345678 the same cycle.
- Reset mid-clear: assert rst at clr_ptr=10 → busy stays high 32 further edges after release. A we=1 write of r4=0x1 during busy is dropped; r4 reads 0 afterwards.
- Generalised config WIDTH=16, DEPTH=20, NREAD=4: write r1=0x0001, r2=0x0002, r19=0xBEEF; ports read 1,2,19,25 simultaneously → 0x0001, 0x0002, 0xBEEF, 0x0000. A write to wa=25 is ignored.
